// File: rtl/rtc_bus_driver.sv
// ============================================================================
// Module      : rtc_bus_driver
// Description : Timed multiplexed address/data bus-cycle engine for the RTC
//               port (address/ALE, CS+WR or CS+RD, recovery, done handshake).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rtc_bus_driver #(
    parameter int T_PHASE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       contro_escribe,
    input  logic       contro_lee,
    input  logic       contro_listo,
    input  logic [7:0] Dir,
    input  logic [7:0] Dato,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       ale,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic [7:0] dato_leido,
    output logic       dato_valido,
    output logic       fin,
    output logic       busy
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ADDR     = 3'd1;
    localparam logic [2:0] S_HOLD     = 3'd2;
    localparam logic [2:0] S_DATA     = 3'd3;
    localparam logic [2:0] S_RECOV    = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;
    localparam logic [2:0] S_WAIT_CLR = 3'd6;

    localparam logic [3:0] c_last = 4'(T_PHASE - 1);

    logic [2:0] r_state;
    logic [2:0] w_next;
    logic [3:0] r_cnt;
    logic       r_is_write;
    logic [7:0] r_addr;
    logic [7:0] r_data;
    logic [7:0] r_hold;

    logic [7:0] r_ad_out;
    logic       r_ad_oe;
    logic       r_ale;
    logic       r_cs_n;
    logic       r_rd_n;
    logic       r_wr_n;
    logic [7:0] r_dato_leido;
    logic       r_dato_valido;
    logic       r_fin;
    logic       r_busy;

    logic       w_start;
    logic       w_phase_end;
    logic       w_timed;
    logic [7:0] w_addr;
    logic [7:0] w_ad_out;
    logic       w_ad_oe;
    logic       w_ale;
    logic       w_cs_n;
    logic       w_rd_n;
    logic       w_wr_n;
    logic       w_fin;
    logic       w_dato_valido;
    logic       w_busy;

    assign w_start     = (r_state == S_IDLE) && !contro_listo && (contro_escribe || contro_lee);
    assign w_phase_end = (r_cnt == c_last);
    assign w_timed     = (r_state == S_ADDR) || (r_state == S_HOLD) ||
                         (r_state == S_DATA) || (r_state == S_RECOV);
    // On the IDLE exit edge the capture registers are not yet loaded.
    assign w_addr      = (r_state == S_IDLE) ? Dir : r_addr;

    // State, counter, captures and registered pins
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= 4'd0;
            r_is_write    <= 1'b0;
            r_addr        <= 8'h00;
            r_data        <= 8'h00;
            r_hold        <= 8'h00;
            r_ad_out      <= 8'h00;
            r_ad_oe       <= 1'b0;
            r_ale         <= 1'b0;
            r_cs_n        <= 1'b1;
            r_rd_n        <= 1'b1;
            r_wr_n        <= 1'b1;
            r_dato_leido  <= 8'h00;
            r_dato_valido <= 1'b0;
            r_fin         <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state || !w_timed)
                r_cnt <= 4'd0;
            else
                r_cnt <= r_cnt + 4'd1;

            if (w_start) begin
                r_addr     <= Dir;
                r_data     <= Dato;
                r_is_write <= contro_escribe;
            end

            if (r_state == S_DATA && w_phase_end && !r_is_write)
                r_hold <= ad_in;
            if (w_dato_valido)
                r_dato_leido <= r_hold;

            r_ad_out      <= w_ad_out;
            r_ad_oe       <= w_ad_oe;
            r_ale         <= w_ale;
            r_cs_n        <= w_cs_n;
            r_rd_n        <= w_rd_n;
            r_wr_n        <= w_wr_n;
            r_dato_valido <= w_dato_valido;
            r_fin         <= w_fin;
            r_busy        <= w_busy;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (w_start)     w_next = S_ADDR;
            S_ADDR:     if (w_phase_end) w_next = S_HOLD;
            S_HOLD:     if (w_phase_end) w_next = S_DATA;
            S_DATA:     if (w_phase_end) w_next = S_RECOV;
            S_RECOV:    if (w_phase_end) w_next = S_DONE;
            S_DONE:                      w_next = S_WAIT_CLR;
            S_WAIT_CLR: if (!contro_escribe && !contro_lee) w_next = S_IDLE;
            default:                     w_next = S_IDLE;
        endcase
    end

    // Pin values are decoded from the next state so they appear in the same
    // cycle as the state they belong to, while staying fully registered.
    always_comb begin
        w_ad_out      = r_ad_out;
        w_ad_oe       = 1'b0;
        w_ale         = 1'b0;
        w_cs_n        = 1'b1;
        w_rd_n        = 1'b1;
        w_wr_n        = 1'b1;
        w_fin         = 1'b0;
        w_dato_valido = 1'b0;
        w_busy        = (w_next != S_IDLE);
        case (w_next)
            S_ADDR: begin
                w_ad_out = w_addr;
                w_ad_oe  = 1'b1;
                w_ale    = 1'b1;
            end
            S_HOLD: begin
                w_ad_out = r_addr;
                w_ad_oe  = 1'b1;
            end
            S_DATA: begin
                w_cs_n = 1'b0;
                if (r_is_write) begin
                    w_ad_out = r_data;
                    w_ad_oe  = 1'b1;
                    w_wr_n   = 1'b0;
                end else begin
                    w_rd_n = 1'b0;
                end
            end
            S_DONE: begin
                w_fin         = 1'b1;
                w_dato_valido = !r_is_write;
            end
            default: ;
        endcase
    end

    assign ad_out      = r_ad_out;
    assign ad_oe       = r_ad_oe;
    assign ale         = r_ale;
    assign cs_n        = r_cs_n;
    assign rd_n        = r_rd_n;
    assign wr_n        = r_wr_n;
    assign dato_leido  = r_dato_leido;
    assign dato_valido = r_dato_valido;
    assign fin         = r_fin;
    assign busy        = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_rtc_bus_driver.sv
// ============================================================================
// Module      : tb_rtc_bus_driver
// Description : Directed self-checking bench for rtc_bus_driver (T_PHASE 4 and 1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rtc_bus_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic       esc, lee, listo;
    logic [7:0] dir, dato, ad_in;
    logic [7:0] ad_out, dato_leido;
    logic       ad_oe, ale, cs_n, rd_n, wr_n, dato_valido, fin, busy;

    logic       esc1, lee1, listo1;
    logic [7:0] dir1, dato1, ad_in1;
    logic [7:0] ad_out1, dato_leido1;
    logic       ad_oe1, ale1, cs_n1, rd_n1, wr_n1, dato_valido1, fin1, busy1;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    rtc_bus_driver #(.T_PHASE(4)) dut (
        .clk(clk), .reset(reset),
        .contro_escribe(esc), .contro_lee(lee), .contro_listo(listo),
        .Dir(dir), .Dato(dato), .ad_in(ad_in),
        .ad_out(ad_out), .ad_oe(ad_oe), .ale(ale), .cs_n(cs_n),
        .rd_n(rd_n), .wr_n(wr_n), .dato_leido(dato_leido),
        .dato_valido(dato_valido), .fin(fin), .busy(busy)
    );

    rtc_bus_driver #(.T_PHASE(1)) dut1 (
        .clk(clk), .reset(reset),
        .contro_escribe(esc1), .contro_lee(lee1), .contro_listo(listo1),
        .Dir(dir1), .Dato(dato1), .ad_in(ad_in1),
        .ad_out(ad_out1), .ad_oe(ad_oe1), .ale(ale1), .cs_n(cs_n1),
        .rd_n(rd_n1), .wr_n(wr_n1), .dato_leido(dato_leido1),
        .dato_valido(dato_valido1), .fin(fin1), .busy(busy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Walks one full T_PHASE=4 cycle (17 cycles after the request edge),
    // checking every pin in every cycle against the expected phase values.
    task automatic run_cycle4(input bit is_wr, input logic [7:0] a, input logic [7:0] d,
                              input logic [7:0] rdata, input bit listo_mid);
        int ph;
        ad_in = 8'hC3;
        for (int i = 1; i <= 17; i++) begin
            tick();
            if (i == 1) begin
                dir  = ~a;
                dato = ~d;
            end
            if (i == 2 && listo_mid) listo = 1'b1;
            if (i == 8)  ad_in = rdata;
            if (i == 13) ad_in = ~rdata;
            ph = (i - 1) / 4;
            chk($sformatf("c%0d busy", i), {7'd0, busy}, 8'd1);
            chk($sformatf("c%0d fin", i), {7'd0, fin}, {7'd0, (i == 17)});
            chk($sformatf("c%0d dato_valido", i), {7'd0, dato_valido},
                {7'd0, (i == 17) && !is_wr});
            chk($sformatf("c%0d ale", i), {7'd0, ale}, {7'd0, (ph == 0)});
            chk($sformatf("c%0d cs_n", i), {7'd0, cs_n}, {7'd0, (ph != 2)});
            chk($sformatf("c%0d wr_n", i), {7'd0, wr_n}, {7'd0, !(ph == 2 && is_wr)});
            chk($sformatf("c%0d rd_n", i), {7'd0, rd_n}, {7'd0, !(ph == 2 && !is_wr)});
            chk($sformatf("c%0d ad_oe", i), {7'd0, ad_oe},
                {7'd0, (ph == 0) || (ph == 1) || (ph == 2 && is_wr)});
            if (ph == 0 || ph == 1) chk($sformatf("c%0d ad_out addr", i), ad_out, a);
            if (ph == 2 && is_wr)   chk($sformatf("c%0d ad_out data", i), ad_out, d);
            if (i == 17 && !is_wr)  chk("read data", dato_leido, rdata);
        end
    endtask

    initial begin
        reset = 1'b1; esc = 0; lee = 0; listo = 0; dir = 0; dato = 0; ad_in = 0;
        esc1 = 0; lee1 = 0; listo1 = 0; dir1 = 0; dato1 = 0; ad_in1 = 0;
        tick(); tick();
        reset = 1'b0;
        chk("rst ale", {7'd0, ale}, 8'd0);
        chk("rst cs_n", {7'd0, cs_n}, 8'd1);
        chk("rst rd_n", {7'd0, rd_n}, 8'd1);
        chk("rst wr_n", {7'd0, wr_n}, 8'd1);
        chk("rst ad_oe", {7'd0, ad_oe}, 8'd0);
        chk("rst ad_out", ad_out, 8'h00);
        chk("rst busy", {7'd0, busy}, 8'd0);
        chk("rst fin", {7'd0, fin}, 8'd0);
        chk("rst dato_leido", dato_leido, 8'h00);
        tick();
        chk("idle busy", {7'd0, busy}, 8'd0);

        // Write 0x5A to 0x21, then hold the request 3 cycles past fin
        dir = 8'h21; dato = 8'h5A; esc = 1'b1;
        run_cycle4(1'b1, 8'h21, 8'h5A, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("waitclr ale", {7'd0, ale}, 8'd0);
            chk("waitclr busy", {7'd0, busy}, 8'd1);
            chk("waitclr fin", {7'd0, fin}, 8'd0);
        end
        esc = 1'b0;
        tick();
        chk("back to idle", {7'd0, busy}, 8'd0);

        // Read from 0xF1 returning 0x37
        dir = 8'hF1; dato = 8'h00; lee = 1'b1;
        run_cycle4(1'b0, 8'hF1, 8'h00, 8'h37, 1'b0);
        lee = 1'b0;
        tick();
        chk("post read dv", {7'd0, dato_valido}, 8'd0);
        chk("post read hold", dato_leido, 8'h37);
        tick();
        chk("post read idle", {7'd0, busy}, 8'd0);

        // Both requests: write wins
        dir = 8'h33; dato = 8'h44; esc = 1'b1; lee = 1'b1;
        run_cycle4(1'b1, 8'h33, 8'h44, 8'h00, 1'b0);
        chk("dato_leido kept", dato_leido, 8'h37);
        esc = 1'b0; lee = 1'b0;
        tick(); tick();

        // Inhibit holds off the start; raising it mid-cycle does not abort
        listo = 1'b1; dir = 8'h10; dato = 8'h20; esc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("inhibit busy", {7'd0, busy}, 8'd0);
            chk("inhibit ale", {7'd0, ale}, 8'd0);
        end
        listo = 1'b0;
        run_cycle4(1'b1, 8'h10, 8'h20, 8'h00, 1'b1);
        esc = 1'b0; listo = 1'b0;
        tick(); tick();

        // Reset during the write data phase
        dir = 8'h55; dato = 8'h66; esc = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        chk("pre-reset wr_n", {7'd0, wr_n}, 8'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0; esc = 1'b0;
        chk("abort wr_n", {7'd0, wr_n}, 8'd1);
        chk("abort cs_n", {7'd0, cs_n}, 8'd1);
        chk("abort ad_oe", {7'd0, ad_oe}, 8'd0);
        chk("abort busy", {7'd0, busy}, 8'd0);
        chk("abort fin", {7'd0, fin}, 8'd0);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("no fin after abort", {7'd0, fin}, 8'd0);
        end
        dir = 8'h77; dato = 8'h88; esc = 1'b1;
        run_cycle4(1'b1, 8'h77, 8'h88, 8'h00, 1'b0);
        esc = 1'b0;
        tick(); tick();

        // T_PHASE=1 write
        dir1 = 8'hA5; dato1 = 8'h3C; esc1 = 1'b1;
        tick();
        chk("t1 c1 ale", {7'd0, ale1}, 8'd1);
        chk("t1 c1 ad_out", ad_out1, 8'hA5);
        tick();
        chk("t1 c2 ale", {7'd0, ale1}, 8'd0);
        chk("t1 c2 ad_oe", {7'd0, ad_oe1}, 8'd1);
        chk("t1 c2 ad_out", ad_out1, 8'hA5);
        tick();
        chk("t1 c3 wr_n", {7'd0, wr_n1}, 8'd0);
        chk("t1 c3 cs_n", {7'd0, cs_n1}, 8'd0);
        chk("t1 c3 ad_out", ad_out1, 8'h3C);
        chk("t1 c3 fin", {7'd0, fin1}, 8'd0);
        tick();
        chk("t1 c4 wr_n", {7'd0, wr_n1}, 8'd1);
        chk("t1 c4 ad_oe", {7'd0, ad_oe1}, 8'd0);
        chk("t1 c4 fin", {7'd0, fin1}, 8'd0);
        tick();
        chk("t1 c5 fin", {7'd0, fin1}, 8'd1);
        chk("t1 c5 dato_valido", {7'd0, dato_valido1}, 8'd0);
        esc1 = 1'b0;
        tick();
        chk("t1 c6 fin", {7'd0, fin1}, 8'd0);
        tick();
        chk("t1 idle", {7'd0, busy1}, 8'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
